// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, valid/ready in and out.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             done_valid,
  input  logic             done_ready,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fs_d, fs_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
`endif

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d   = SHIFT;
          a_sr_d    = a;
          b_sr_d    = b;
          diff_sr_d = '0;
          borrow_d  = 1'b0;
          cnt_d     = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d   = a[WIDTH-1];
          b_msb_d   = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        borrow_d  = fs_bout;
        diff_sr_d = {fs_d, diff_sr_q[WIDTH-1:1]};
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        // Counter holds on the final bit so it never wraps.
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        if (done_ready) begin
          state_d   = IDLE;
          diff_sr_d = '0;
          borrow_d  = 1'b0;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == SHIFT);
  assign done_valid  = (state_q == DONE);
  assign diff        = done_valid ? diff_sr_q : '0;
  assign borrow      = done_valid & borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  assign ovf = done_valid & (a_msb_q != b_msb_q)
             & (diff_sr_q[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a, b;
  logic [7:0] diff;
  logic       borrow;
  logic       done_valid;
  logic       done_ready;
  logic       busy;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .diff        (diff),
    .borrow      (borrow),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
`ifdef SERIAL_SUB_OVF_EN
    .ovf         (ovf),
`endif
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accept and waits for done; returns observations only.
  task automatic run_op(input logic [7:0] a_i, input logic [7:0] b_i,
                        input bit keep_valid, output int lat,
                        output logic busy_o);
    int n;
    n = 0;
    while (!start_ready && n < 30) begin
      tick();
      n++;
    end
    a = a_i;
    b = b_i;
    start_valid = 1'b1;
    tick();
    if (!keep_valid) start_valid = 1'b0;
    busy_o = busy;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      if (done_valid) begin
        lat = i - 1;
        break;
      end
      tick();
    end
    if (done_valid && lat < 0) lat = 30;
  endtask

  task automatic handshake();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_start_ready got=%b exp=1", start_ready);
    end
    checks++;
    if (done_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags done=%b busy=%b exp=0", done_valid, busy);
    end
    checks++;
    if (diff !== 8'h00 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs diff=%h borrow=%b exp=00/0", diff, borrow);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic bz;
    run_op(8'h35, 8'h12, 1'b0, lat, bz);
    checks++;
    if (bz !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b exp=1", bz);
    end
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=8", lat);
    end
    checks++;
    if (diff !== 8'h23 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL basic_result diff=%h borrow=%b exp=23/0", diff, borrow);
    end
    handshake();
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 ||
        diff !== 8'h00 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL basic_release rdy=%b dv=%b diff=%h bo=%b exp=1/0/00/0",
               start_ready, done_valid, diff, borrow);
    end
  endtask

  task automatic test_borrow();
    int lat;
    logic bz;
    run_op(8'h12, 8'h35, 1'b0, lat, bz);
    checks++;
    if (diff !== 8'hDD || borrow !== 1'b1 || lat !== 8) begin
      failures++;
      $display("FAIL borrow_12_35 diff=%h borrow=%b lat=%0d exp=DD/1/8",
               diff, borrow, lat);
    end
    handshake();
    run_op(8'h00, 8'h01, 1'b0, lat, bz);
    checks++;
    if (diff !== 8'hFF || borrow !== 1'b1) begin
      failures++;
      $display("FAIL borrow_00_01 diff=%h borrow=%b exp=FF/1", diff, borrow);
    end
    handshake();
  endtask

  task automatic test_ovf();
    int lat;
    logic bz;
    run_op(8'h80, 8'h01, 1'b0, lat, bz);
    checks++;
    if (diff !== 8'h7F || borrow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_80_01 diff=%h borrow=%b exp=7F/0", diff, borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", ovf);
    end
`endif
    handshake();
    run_op(8'h7F, 8'h01, 1'b0, lat, bz);
    checks++;
    if (diff !== 8'h7E || borrow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_7F_01 diff=%h borrow=%b exp=7E/0", diff, borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", ovf);
    end
`endif
    handshake();
  endtask

  task automatic test_hold();
    int lat;
    logic bz;
    run_op(8'hC3, 8'h3C, 1'b0, lat, bz);
    start_valid = 1'b1;
    a = 8'h01;
    b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (diff !== 8'h87 || borrow !== 1'b0 || done_valid !== 1'b1 ||
          start_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d diff=%h bo=%b dv=%b rdy=%b exp=87/0/1/0",
                 i, diff, borrow, done_valid, start_ready);
      end
    end
    start_valid = 1'b0;
    handshake();
  endtask

  task automatic test_abort();
    int lat;
    logic bz;
    a = 8'hF0;
    b = 8'h0F;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done_valid !== 1'b0 || start_ready !== 1'b1 ||
        diff !== 8'h00 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL abort_async busy=%b dv=%b rdy=%b diff=%h bo=%b",
               busy, done_valid, start_ready, diff, borrow);
    end
    tick();
    rst = 1'b0;
    tick();
    run_op(8'hAA, 8'h55, 1'b0, lat, bz);
    checks++;
    if (diff !== 8'h55 || borrow !== 1'b0 || lat !== 8) begin
      failures++;
      $display("FAIL abort_next diff=%h borrow=%b lat=%0d exp=55/0/8",
               diff, borrow, lat);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bz;
    run_op(8'h35, 8'h12, 1'b1, lat, bz);
    checks++;
    if (diff !== 8'h23 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first diff=%h borrow=%b exp=23/0", diff, borrow);
    end
    a = 8'h10;
    b = 8'h20;
    handshake();
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap rdy=%b dv=%b busy=%b exp=1/0/0",
               start_ready, done_valid, busy);
    end
    tick();
    start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept busy=%b rdy=%b exp=1/0", busy, start_ready);
    end
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (diff !== 8'hF0 || borrow !== 1'b1 || lat !== 8) begin
      failures++;
      $display("FAIL b2b_second diff=%h borrow=%b lat=%0d exp=F0/1/8",
               diff, borrow, lat);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ovf();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
